// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage 16-bit core.
// Generates the PC and pipeline register enables and the IF/ID and ID/EX bubble
// controls from load-use hazards, redirects, memory stalls and halt/error
// retirement. It also keeps a saturating stall-cycle counter for debug.
module hazard_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  id_rs,
   input  logic [2:0]  id_rt,
   input  logic        id_rs_vld,
   input  logic        id_rt_vld,
   input  logic        ex_load,
   input  logic [2:0]  ex_dst,
   input  logic        ex_redirect,
   input  logic        imem_stall,
   input  logic        dmem_stall,
   input  logic        mem_halt,
   input  logic        mem_err,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        idex_en,
   output logic        exmem_en,
   output logic        memwb_en,
   output logic        ifid_bubble,
   output logic        idex_bubble,
   output logic        halted,
   output logic        err_halt,
   output logic [15:0] stall_cycles
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        squash_pend_q, squash_pend_d;
   logic        err_r_q, err_r_d;
   logic [15:0] stall_cycles_q, stall_cycles_d;
   logic        lu;

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      if (v == 16'hFFFF) begin
         return v;
      end
      return v + 16'd1;
   endfunction

   // Load in EX whose destination feeds a source the ID instruction actually reads.
   assign lu = ex_load & ((id_rs_vld & (id_rs == ex_dst)) |
                          (id_rt_vld & (id_rt == ex_dst)));

   assign stall_cycles = stall_cycles_q;

   // Mealy control outputs and next-state; outputs are forced idle while rst is high.
   always_comb begin
      pc_en          = 1'b0;
      ifid_en        = 1'b0;
      idex_en        = 1'b0;
      exmem_en       = 1'b0;
      memwb_en       = 1'b0;
      ifid_bubble    = 1'b0;
      idex_bubble    = 1'b0;
      halted         = 1'b0;
      err_halt       = 1'b0;
      state_d        = state_q;
      squash_pend_d  = squash_pend_q;
      err_r_d        = err_r_q;
      stall_cycles_d = stall_cycles_q;
      if (!rst) begin
         case (state_q)
            RUN: begin
               pc_en    = 1'b1;
               ifid_en  = 1'b1;
               idex_en  = 1'b1;
               exmem_en = 1'b1;
               memwb_en = 1'b1;
               if (dmem_stall) begin
                  // Full freeze; held registers re-present the same hazards later.
                  pc_en    = 1'b0;
                  ifid_en  = 1'b0;
                  idex_en  = 1'b0;
                  exmem_en = 1'b0;
                  memwb_en = 1'b0;
               end else if (mem_halt | mem_err) begin
                  // Let only the retiring instruction move into WB.
                  pc_en    = 1'b0;
                  ifid_en  = 1'b0;
                  idex_en  = 1'b0;
                  exmem_en = 1'b0;
                  state_d  = DRAIN;
                  err_r_d  = mem_err;
               end else if (ex_redirect) begin
                  // PC takes the target; if IF is busy the word arriving later
                  // belongs to the wrong path and must be squashed once.
                  ifid_bubble   = 1'b1;
                  idex_bubble   = 1'b1;
                  squash_pend_d = imem_stall;
               end else if (lu) begin
                  pc_en       = 1'b0;
                  ifid_en     = 1'b0;
                  idex_bubble = 1'b1;
               end else if (imem_stall) begin
                  pc_en       = 1'b0;
                  ifid_bubble = 1'b1;
               end else if (squash_pend_q) begin
                  // Stale fetched word: drop it and refetch the target.
                  pc_en         = 1'b0;
                  ifid_bubble   = 1'b1;
                  squash_pend_d = 1'b0;
               end
               if (!pc_en) begin
                  stall_cycles_d = sat_inc(stall_cycles_q);
               end
            end
            DRAIN: begin
               state_d = HALTED;
            end
            HALTED: begin
               halted   = 1'b1;
               err_halt = err_r_q;
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= RUN;
         squash_pend_q  <= 1'b0;
         err_r_q        <= 1'b0;
         stall_cycles_q <= 16'd0;
      end else begin
         state_q        <= state_d;
         squash_pend_q  <= squash_pend_d;
         err_r_q        <= err_r_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares them.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  id_rs = 3'd0, id_rt = 3'd0, ex_dst = 3'd0;
   logic        id_rs_vld = 1'b0, id_rt_vld = 1'b0, ex_load = 1'b0;
   logic        ex_redirect = 1'b0, imem_stall = 1'b0, dmem_stall = 1'b0;
   logic        mem_halt = 1'b0, mem_err = 1'b0;
   logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic        ifid_bubble, idex_bubble, halted, err_halt;
   logic [15:0] stall_cycles;

   typedef struct packed {
      logic       rst;
      logic       ld;
      logic [2:0] dst;
      logic [2:0] rs;
      logic       rsv;
      logic [2:0] rt;
      logic       rtv;
      logic       redir;
      logic       imem;
      logic       dmem;
      logic       halt;
      logic       err;
   } in_t;

   typedef struct packed {
      logic [4:0]  en;    // {pc, ifid, idex, exmem, memwb}
      logic [1:0]  bub;   // {ifid, idex}
      logic        hlt;
      logic        eh;
      logic [15:0] cnt;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   int   vec_no = 0;

   hazard_ctrl dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_rs_vld(id_rs_vld), .id_rt_vld(id_rt_vld),
      .ex_load(ex_load), .ex_dst(ex_dst), .ex_redirect(ex_redirect),
      .imem_stall(imem_stall), .dmem_stall(dmem_stall),
      .mem_halt(mem_halt), .mem_err(mem_err),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
      .exmem_en(exmem_en), .memwb_en(memwb_en),
      .ifid_bubble(ifid_bubble), .idex_bubble(idex_bubble),
      .halted(halted), .err_halt(err_halt), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   function automatic in_t vin(input logic r, input logic ld, input logic [2:0] dst,
                               input logic [2:0] rs, input logic rsv,
                               input logic [2:0] rt, input logic rtv,
                               input logic redir, input logic imem, input logic dmem,
                               input logic halt, input logic err);
      in_t v;
      v.rst = r; v.ld = ld; v.dst = dst; v.rs = rs; v.rsv = rsv; v.rt = rt; v.rtv = rtv;
      v.redir = redir; v.imem = imem; v.dmem = dmem; v.halt = halt; v.err = err;
      return v;
   endfunction

   function automatic exp_t ex(input logic [4:0] en, input logic [1:0] bub,
                               input logic h, input logic e, input logic [15:0] c);
      exp_t x;
      x.en = en; x.bub = bub; x.hlt = h; x.eh = e; x.cnt = c;
      return x;
   endfunction

   task automatic apply(input in_t v);
      rst = v.rst; ex_load = v.ld; ex_dst = v.dst;
      id_rs = v.rs; id_rs_vld = v.rsv; id_rt = v.rt; id_rt_vld = v.rtv;
      ex_redirect = v.redir; imem_stall = v.imem; dmem_stall = v.dmem;
      mem_halt = v.halt; mem_err = v.err;
   endtask

   // One cycle of stimulus with its expected response queued.
   task automatic cyc(input in_t v, input exp_t e);
      @(posedge clk);
      #1;
      apply(v);
      sbq.push_back(e);
   endtask

   task automatic drive_only(input in_t v);
      @(posedge clk);
      #1;
      apply(v);
   endtask

   // Monitor: outputs are valid every cycle; compare mid-cycle on the falling edge.
   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         exp_t e;
         logic [10:0] act_ctl, exp_ctl;
         e = sbq.pop_front();
         vec_no++;
         act_ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                    ifid_bubble, idex_bubble, halted, err_halt, 2'b00};
         exp_ctl = {e.en, e.bub, e.hlt, e.eh, 2'b00};
         checks++;
         if (act_ctl !== exp_ctl) begin
            errors++;
            $display("FAIL vec%0d ctl {en5,bub2,halted,err_halt} got %b exp %b",
                     vec_no, act_ctl[10:2], exp_ctl[10:2]);
         end
         checks++;
         if (stall_cycles !== e.cnt) begin
            errors++;
            $display("FAIL vec%0d stall_cycles got %h exp %h", vec_no, stall_cycles, e.cnt);
         end
      end
   end

   localparam logic [4:0] EALL = 5'b11111;
   localparam logic [4:0] ENONE = 5'b00000;
   localparam logic [4:0] ELU = 5'b00111;
   localparam logic [4:0] EIF = 5'b01111;
   localparam logic [4:0] EWB = 5'b00001;

   initial begin
      in_t idle, rstv, lu_rs, nolu, lu_rt, rd, rdi, im, dm, frz, rdlu, hlt, err, junk;
      idle  = vin(0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
      rstv  = vin(1, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
      lu_rs = vin(0, 1, 3'd3, 3'd3, 1, 3'd1, 1, 0, 0, 0, 0, 0);
      nolu  = vin(0, 1, 3'd2, 3'd2, 0, 3'd4, 1, 0, 0, 0, 0, 0);
      lu_rt = vin(0, 1, 3'd5, 3'd5, 0, 3'd5, 1, 0, 0, 0, 0, 0);
      rd    = vin(0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 1, 0, 0, 0, 0);
      rdi   = vin(0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 1, 1, 0, 0, 0);
      im    = vin(0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 1, 0, 0, 0);
      dm    = vin(0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0, 1, 0, 0);
      frz   = vin(0, 1, 3'd3, 3'd3, 1, 3'd0, 0, 1, 0, 1, 0, 0);
      rdlu  = vin(0, 1, 3'd3, 3'd3, 1, 3'd0, 0, 1, 0, 0, 0, 0);
      hlt   = vin(0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0, 0, 1, 0);
      err   = vin(0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0, 0, 0, 1);
      junk  = vin(0, 1, 3'd3, 3'd3, 1, 3'd3, 1, 1, 1, 0, 1, 1);

      // Reset and idle
      cyc(rstv,  ex(ENONE, 2'b00, 0, 0, 16'd0));
      cyc(idle,  ex(EALL,  2'b00, 0, 0, 16'd0));
      // Load-use on rs, then release
      cyc(lu_rs, ex(ELU,   2'b01, 0, 0, 16'd0));
      cyc(idle,  ex(EALL,  2'b00, 0, 0, 16'd1));
      // Load with matching rs that is not read: no hazard; then hazard on rt
      cyc(nolu,  ex(EALL,  2'b00, 0, 0, 16'd1));
      cyc(lu_rt, ex(ELU,   2'b01, 0, 0, 16'd1));
      cyc(idle,  ex(EALL,  2'b00, 0, 0, 16'd2));
      // Redirect with imem ready: two bubbles, no squash afterwards
      cyc(rd,    ex(EALL,  2'b11, 0, 0, 16'd2));
      cyc(idle,  ex(EALL,  2'b00, 0, 0, 16'd2));
      // Redirect with imem busy 3 cycles, then one refetch cycle
      cyc(rdi,   ex(EALL,  2'b11, 0, 0, 16'd2));
      cyc(im,    ex(EIF,   2'b10, 0, 0, 16'd2));
      cyc(im,    ex(EIF,   2'b10, 0, 0, 16'd3));
      cyc(idle,  ex(EIF,   2'b10, 0, 0, 16'd4));
      cyc(idle,  ex(EALL,  2'b00, 0, 0, 16'd5));
      // Freeze beats redirect and load-use; redirect applies when the stall drops
      cyc(frz,   ex(ENONE, 2'b00, 0, 0, 16'd5));
      cyc(rdlu,  ex(EALL,  2'b11, 0, 0, 16'd6));
      cyc(idle,  ex(EALL,  2'b00, 0, 0, 16'd6));
      // Plain imem stall leaves no pending squash
      cyc(im,    ex(EIF,   2'b10, 0, 0, 16'd6));
      cyc(idle,  ex(EALL,  2'b00, 0, 0, 16'd7));
      // Pending squash survives a dmem freeze
      cyc(rdi,   ex(EALL,  2'b11, 0, 0, 16'd7));
      cyc(dm,    ex(ENONE, 2'b00, 0, 0, 16'd7));
      cyc(idle,  ex(EIF,   2'b10, 0, 0, 16'd8));
      cyc(idle,  ex(EALL,  2'b00, 0, 0, 16'd9));
      // Halt: WB only, drain, then halted and held
      cyc(hlt,   ex(EWB,   2'b00, 0, 0, 16'd9));
      cyc(idle,  ex(ENONE, 2'b00, 0, 0, 16'd10));
      for (int i = 0; i < 11; i++) begin
         cyc((i % 2) ? junk : idle, ex(ENONE, 2'b00, 1, 0, 16'd10));
      end
      // Asynchronous reset mid-HALTED takes effect before the next edge
      cyc(rstv,  ex(ENONE, 2'b00, 0, 0, 16'd0));
      cyc(idle,  ex(EALL,  2'b00, 0, 0, 16'd0));
      // Reset mid-DRAIN returns to RUN
      cyc(hlt,   ex(EWB,   2'b00, 0, 0, 16'd0));
      cyc(rstv,  ex(ENONE, 2'b00, 0, 0, 16'd0));
      cyc(idle,  ex(EALL,  2'b00, 0, 0, 16'd0));
      // Error retirement sets err_halt
      cyc(err,   ex(EWB,   2'b00, 0, 0, 16'd0));
      cyc(idle,  ex(ENONE, 2'b00, 0, 0, 16'd1));
      for (int i = 0; i < 10; i++) begin
         cyc(idle, ex(ENONE, 2'b00, 1, 1, 16'd1));
      end
      // Saturation: 65534 frozen cycles reach 0xFFFE, then three more stick at 0xFFFF
      cyc(rstv,  ex(ENONE, 2'b00, 0, 0, 16'd0));
      repeat (65534) drive_only(dm);
      cyc(dm,    ex(ENONE, 2'b00, 0, 0, 16'hFFFE));
      cyc(dm,    ex(ENONE, 2'b00, 0, 0, 16'hFFFF));
      cyc(dm,    ex(ENONE, 2'b00, 0, 0, 16'hFFFF));
      cyc(idle,  ex(EALL,  2'b00, 0, 0, 16'hFFFF));
      cyc(rstv,  ex(ENONE, 2'b00, 0, 0, 16'd0));

      for (int k = 0; k < 5 && sbq.size() > 0; k++) begin
         @(posedge clk);
      end
      if (sbq.size() > 0) begin
         errors++;
         $display("FAIL drain scoreboard left %0d entries exp 0", sbq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
